// File: rtl/hazard_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// master = pipeline side (drives ID/EX status), slave = controller.
interface hazard_if;
  logic       MemRead_EX;
  logic [2:0] rtaddr_EX;
  logic [2:0] rsaddr_ID;
  logic [2:0] rtaddr_ID;
  logic       UsesRt_ID;
  logic       BranchTaken_EX;
  logic       MultiCycle_EX;
  logic       PCWrite;
  logic       IFIDwrite;
  logic       IFIDflush;
  logic       IDEXflush;
  logic       mc_start;
  logic       mc_done;

  modport master (
    output MemRead_EX, rtaddr_EX, rsaddr_ID, rtaddr_ID, UsesRt_ID, BranchTaken_EX, MultiCycle_EX,
    input  PCWrite, IFIDwrite, IFIDflush, IDEXflush, mc_start, mc_done
  );

  modport slave (
    input  MemRead_EX, rtaddr_EX, rsaddr_ID, rtaddr_ID, UsesRt_ID, BranchTaken_EX, MultiCycle_EX,
    output PCWrite, IFIDwrite, IFIDflush, IDEXflush, mc_start, mc_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, EX branch flush, multi-cycle EX hold.
// Define HAZARD_PERF_EN to add saturating stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_n,
  hazard_if.slave    hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  typedef enum logic {StRun, StMcBusy} state_e;

  localparam bit          McMulti    = (MC_CYCLES > 1);
  localparam int unsigned CntInitInt = McMulti ? (MC_CYCLES - 2) : 0;
  localparam logic [3:0]  CntInit    = CntInitInt[3:0];

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic load_use;
  logic pc_write, ifid_write, ifid_flush, idex_flush, mc_start, mc_done;

  // A load into r0 never creates a dependency.
  assign load_use = hz.MemRead_EX && (hz.rtaddr_EX != 3'd0) &&
                    ((hz.rtaddr_EX == hz.rsaddr_ID) ||
                     (hz.UsesRt_ID && (hz.rtaddr_EX == hz.rtaddr_ID)));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun: begin
        if (!hz.BranchTaken_EX && hz.MultiCycle_EX && McMulti) begin
          state_d = StMcBusy;
          cnt_d   = CntInit;
        end
      end
      StMcBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mc_start   = 1'b0;
    mc_done    = 1'b0;
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hz.BranchTaken_EX) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (hz.MultiCycle_EX) begin
            mc_start   = 1'b1;
            mc_done    = !McMulti;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
        end
        StMcBusy: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          mc_done    = (cnt_q == 4'd0);
        end
      endcase
    end
  end

  assign hz.PCWrite   = pc_write;
  assign hz.IFIDwrite = ifid_write;
  assign hz.IFIDflush = ifid_flush;
  assign hz.IDEXflush = idex_flush;
  assign hz.mc_start  = mc_start;
  assign hz.mc_done   = mc_done;

`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        branch_flush;

  assign branch_flush = (state_q == StRun) && hz.BranchTaken_EX;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (branch_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three instances (MC_CYCLES = 4, 1, 8) share stimulus
// and are compared each cycle against a stall-budget reference model.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_if if4 ();
  hazard_if if1 ();
  hazard_if if8 ();

`ifdef HAZARD_PERF_EN
  logic [15:0] sc4, fc4, sc1, fc1, sc8, fc8;
  hazard_ctrl #(.MC_CYCLES(4)) dut4 (.clk_i(clk), .rst_n(rst_n), .hz(if4.slave),
                                     .stall_cnt(sc4), .flush_cnt(fc4));
  hazard_ctrl #(.MC_CYCLES(1)) dut1 (.clk_i(clk), .rst_n(rst_n), .hz(if1.slave),
                                     .stall_cnt(sc1), .flush_cnt(fc1));
  hazard_ctrl #(.MC_CYCLES(8)) dut8 (.clk_i(clk), .rst_n(rst_n), .hz(if8.slave),
                                     .stall_cnt(sc8), .flush_cnt(fc8));
`else
  hazard_ctrl #(.MC_CYCLES(4)) dut4 (.clk_i(clk), .rst_n(rst_n), .hz(if4.slave));
  hazard_ctrl #(.MC_CYCLES(1)) dut1 (.clk_i(clk), .rst_n(rst_n), .hz(if1.slave));
  hazard_ctrl #(.MC_CYCLES(8)) dut8 (.clk_i(clk), .rst_n(rst_n), .hz(if8.slave));
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: stall cycles still owed after the current one, perf counts.
  int ncyc[3] = '{4, 1, 8};
  int busy[3] = '{0, 0, 0};
  int sc[3]   = '{0, 0, 0};
  int fc[3]   = '{0, 0, 0};

  logic       in_mr, in_use, in_br, in_mc;
  logic [2:0] in_rte, in_rsi, in_rti;

  task automatic set_in(input logic mr, input logic [2:0] rte, input logic [2:0] rsi,
                        input logic [2:0] rti, input logic use_rt, input logic br,
                        input logic mc);
    in_mr = mr; in_rte = rte; in_rsi = rsi; in_rti = rti;
    in_use = use_rt; in_br = br; in_mc = mc;
    if4.MemRead_EX = mr; if4.rtaddr_EX = rte; if4.rsaddr_ID = rsi; if4.rtaddr_ID = rti;
    if4.UsesRt_ID = use_rt; if4.BranchTaken_EX = br; if4.MultiCycle_EX = mc;
    if1.MemRead_EX = mr; if1.rtaddr_EX = rte; if1.rsaddr_ID = rsi; if1.rtaddr_ID = rti;
    if1.UsesRt_ID = use_rt; if1.BranchTaken_EX = br; if1.MultiCycle_EX = mc;
    if8.MemRead_EX = mr; if8.rtaddr_EX = rte; if8.rsaddr_ID = rsi; if8.rtaddr_ID = rti;
    if8.UsesRt_ID = use_rt; if8.BranchTaken_EX = br; if8.MultiCycle_EX = mc;
  endtask

  // Expected {PCWrite, IFIDwrite, IFIDflush, IDEXflush, mc_start, mc_done}.
  function automatic logic [5:0] model_out(int i);
    logic hazard;
    if (!rst_n) return 6'b001100;
    if (busy[i] > 0) return {5'b00010, busy[i] == 1};
    if (in_br) return 6'b111100;
    if (in_mc) return {5'b00011, ncyc[i] == 1};
    hazard = in_mr && (in_rte != 3'd0) &&
             ((in_rte == in_rsi) || (in_use && (in_rte == in_rti)));
    return hazard ? 6'b000100 : 6'b110000;
  endfunction

  function automatic logic [5:0] obs_of(int i);
    case (i)
      0: return {if4.PCWrite, if4.IFIDwrite, if4.IFIDflush, if4.IDEXflush, if4.mc_start,
                 if4.mc_done};
      1: return {if1.PCWrite, if1.IFIDwrite, if1.IFIDflush, if1.IDEXflush, if1.mc_start,
                 if1.mc_done};
      default: return {if8.PCWrite, if8.IFIDwrite, if8.IFIDflush, if8.IDEXflush,
                       if8.mc_start, if8.mc_done};
    endcase
  endfunction

`ifdef HAZARD_PERF_EN
  function automatic logic [31:0] perf_of(int i);
    case (i)
      0: return {sc4, fc4};
      1: return {sc1, fc1};
      default: return {sc8, fc8};
    endcase
  endfunction
`endif

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      busy[i] = 0; sc[i] = 0; fc[i] = 0;
    end
  endtask

  // Check all instances mid-cycle, then advance the model across the next rising edge.
  task automatic step(input string tag);
    logic [5:0] e[3];
    logic [5:0] o;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e[i] = model_out(i);
      o = obs_of(i);
      total++;
      assert (o === e[i]) else begin
        bad++;
        $error("FAIL %s dut%0d: got %b want %b", tag, i, o, e[i]);
      end
`ifdef HAZARD_PERF_EN
      begin
        logic [31:0] p, pe;
        p  = perf_of(i);
        pe = {sc[i][15:0], fc[i][15:0]};
        total++;
        assert (p === pe) else begin
          bad++;
          $error("FAIL %s_perf dut%0d: got %h want %h", tag, i, p, pe);
        end
      end
`endif
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        busy[i] = 0; sc[i] = 0; fc[i] = 0;
      end else begin
        if (!e[i][5] && sc[i] < 65535) sc[i]++;
        if (busy[i] == 0 && in_br && fc[i] < 65535) fc[i]++;
        if (busy[i] > 0) busy[i]--;
        else if (!in_br && in_mc && ncyc[i] > 1) busy[i] = ncyc[i] - 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    set_in(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  initial begin
    set_in(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    step("reset");
    step("reset");
    rst_n = 1'b1;
    step("first_run");

    set_in(1'b1, 3'd3, 3'd3, 3'd5, 1'b0, 1'b0, 1'b0);
    step("loaduse_rs");
    set_in(1'b0, 3'd0, 3'd3, 3'd5, 1'b0, 1'b0, 1'b0);
    step("loaduse_clear");
    set_in(1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0);
    step("load_r0");
    set_in(1'b1, 3'd6, 3'd2, 3'd6, 1'b0, 1'b0, 1'b0);
    step("rt_only_unused");
    set_in(1'b1, 3'd6, 3'd2, 3'd6, 1'b1, 1'b0, 1'b0);
    step("rt_used");
    set_in(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    step("branch_mc");
    idle(1, "after_branch");

    // Multi-cycle op, followed long enough for every instance to drain.
    set_in(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    step("mc_entry");
    idle(9, "mc_busy");

    // Reset asserted during the third MC_BUSY cycle of the 8-cycle instance.
    set_in(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    step("mc8_entry");
    idle(2, "mc8_busy");
    rst_n = 1'b0;
    model_reset();
    step("rst_mid");
    step("rst_hold");
    rst_n = 1'b1;
    step("rst_release");

    for (int k = 0; k < 400; k++) begin
      set_in(($urandom % 3) == 0, 3'($urandom % 8), 3'($urandom % 8), 3'($urandom % 8),
             1'($urandom % 2), ($urandom % 8) == 0, ($urandom % 10) == 0);
      step("random");
    end
    idle(10, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 16-bit, 8-register pipeline. Each cycle it decides whether the IF/ID and ID/EX pipeline registers advance, hold or take a bubble. It covers three cases:
- one-cycle load-use stall;
- branch/jump flush resolved in EX;
- multi-cycle EX operation that holds younger instructions in ID for a configurable number of cycles.

Outputs feed the PC register, IF/ID register (write enable and flush) and the ID/EX register flush input.

## Interface
- MC_CYCLES, 4, EX occupancy of a multi-cycle operation in cycles; legal range 1..16.

- clk_i  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- MemRead_EX  in  1  instruction in EX is a load.
- rtaddr_EX  in  3  load destination register in EX.
- rsaddr_ID  in  3  rs field of the instruction in ID.
- rtaddr_ID  in  3  rt field of the instruction in ID.
- UsesRt_ID  in  1  instruction in ID reads rt as a source.
- BranchTaken_EX  in  1  branch or jump in EX resolved taken.
- MultiCycle_EX  in  1  instruction in EX is a multi-cycle operation.
- PCWrite  out  1  PC update enable.
- IFIDwrite  out  1  IF/ID write enable.
- IFIDflush  out  1  IF/ID clears to NOP at next edge.
- IDEXflush  out  1  ID/EX clears to bubble at next edge.
- mc_start  out  1  one-cycle pulse: multi-cycle unit latches operands.
- mc_done  out  1  one-cycle pulse: multi-cycle result valid this cycle.

## Operation
- States: RUN, MC_BUSY. Down-counter cnt is 4 bits.
- Outputs are combinational from state, cnt and inputs. Default in RUN is PCWrite=1, IFIDwrite=1, flushes=0, pulses=0.
- Priority in RUN, evaluated top to bottom:
  - Branch: if BranchTaken_EX=1, then IFIDflush=1 and IDEXflush=1; PCWrite=1 (target loads); stay RUN. Any concurrent MultiCycle_EX is ignored (no mc_start).
  - Multi-cycle: if MultiCycle_EX=1, then mc_start=1, PCWrite=0, IFIDwrite=0, IDEXflush=1.
    - If MC_CYCLES=1: mc_done=1 in the same cycle; stay RUN.
    - Else: cnt<=MC_CYCLES-2; go to MC_BUSY.
  - Load-use: if MemRead_EX=1, rtaddr_EX!=0, and (rtaddr_EX==rsaddr_ID or (UsesRt_ID and rtaddr_EX==rtaddr_ID)), then PCWrite=0, IFIDwrite=0, IDEXflush=1 for one cycle; stay RUN.
- Register 0 is hardwired zero, so a load to r0 never stalls.
- MC_BUSY:
  - Every cycle: PCWrite=0, IFIDwrite=0, IDEXflush=1.
  - If cnt==0: mc_done=1 and go to RUN. Else cnt<=cnt-1.
  - BranchTaken_EX, MemRead_EX and MultiCycle_EX are ignored (EX holds bubbles).
- Total stall for a multi-cycle operation is exactly MC_CYCLES cycles, counting the entry cycle.

## Timing
- Reset (rst_n low, asynchronous): state=RUN, cnt=0.
- Outputs while in reset: PCWrite=0, IFIDwrite=0, IFIDflush=1, IDEXflush=1, mc_start=0, mc_done=0.
- First normal cycle is the first rising edge after rst_n deasserts.
- Reset asserted in MC_BUSY aborts the operation immediately; no mc_done is produced.
- Latency: control decisions take effect at the next rising edge of the pipeline registers. Load-use inserts exactly one bubble. A branch costs two flushed slots.
- Load-use stall needs no state: the next cycle EX holds a bubble, so the hazard clears by itself.
- mc_start and mc_done never assert outside the cases above. Both assert together only when MC_CYCLES=1.

## Configuration
- HAZARD_PERF_EN defined: adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - stall_cnt increments each cycle PCWrite=0 while out of reset.
  - flush_cnt increments each cycle a branch flush occurs.
  - Both saturate at 16'hFFFF and clear to 0 on reset.
- HAZARD_PERF_EN undefined: these ports and registers are absent; all other behaviour is identical.

## Test plan
- Reset release with all inputs 0 -> first cycle after release gives PCWrite=1, IFIDwrite=1, flushes=0.
- MemRead_EX=1, rtaddr_EX=3, rsaddr_ID=3 -> exactly one cycle of PCWrite=0, IFIDwrite=0, IDEXflush=1. Repeating with rtaddr_EX=0, or with an rt-only match and UsesRt_ID=0 -> no stall.
- BranchTaken_EX=1 together with MultiCycle_EX=1 -> IFIDflush=1, IDEXflush=1, mc_start=0, state stays RUN.
- MC_CYCLES=4, MultiCycle_EX pulsed -> mc_start in cycle 0, PCWrite=0 for cycles 0..3, mc_done in cycle 3, PCWrite=1 in cycle 4.
- MC_CYCLES=1 -> mc_start and mc_done in the same cycle, single stall cycle.
- MC_CYCLES=8, rst_n pulsed low in the third MC_BUSY cycle -> immediate reset outputs, no mc_done, RUN after release.
- HAZARD_PERF_EN defined: after the MC_CYCLES=4 operation plus one branch -> stall_cnt=4, flush_cnt=1.
